// File: rtl/out_uart_tx_pkg.sv
// Shared definitions for the cpu-out UART transmitter: FSM state encodings,
// frame constants and counter-width helper.
package out_uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  localparam int BYTE_BITS = 8;

  // Counter width that stays >= 1 even for a modulus of 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_uart_tx_sync_fifo.sv
// Word FIFO between change detect and the serialiser; full is registered,
// and a push into a full FIFO is accepted only when a pop happens on the same edge.
module out_uart_tx_sync_fifo
  import out_uart_tx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = cnt_w(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count, count_n;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_comb begin
    count_n = count;
    if (do_push && !do_pop)      count_n = count + 1'b1;
    else if (do_pop && !do_push) count_n = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count_n;
      full  <= (count_n == CNT_FULL);
    end
  end

endmodule

// File: rtl/out_uart_tx.sv
// Sends every change of the cpu `out` word as UART frames, low byte first.
// Define OUT_UART_PARITY_EN to insert an even-parity bit after the data bits.
module out_uart_tx
  import out_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  fifo_full,
  output logic                  overflow
);

  localparam int NBYTES = DATA_WIDTH / BYTE_BITS;
  localparam int BAUD_W = cnt_w(CLKS_PER_BIT);
  localparam int BYTE_W = cnt_w(NBYTES);
  localparam int BIT_W  = cnt_w(BYTE_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BYTE_BITS - 1);

  uart_state_t           state, state_n;
  logic [BAUD_W-1:0]     baud_cnt, baud_n;
  logic [BIT_W-1:0]      bit_cnt, bit_n;
  logic [BYTE_W-1:0]     byte_idx, byte_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  par, par_n;
  logic [DATA_WIDTH-1:0] last_q;
  logic                  push, pop, baud_end;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;

  // No valid strobe from the cpu: any value change is a new word.
  assign push = (out_data != last_q);

  out_uart_tx_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (out_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign busy     = (state != S_IDLE) | ~fifo_empty;

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    byte_n  = byte_idx;
    shreg_n = shreg;
    par_n   = par;
    pop     = 1'b0;
    tx      = 1'b1;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_rdata;
          byte_n  = '0;
          baud_n  = '0;
          bit_n   = '0;
          par_n   = 1'b0;
          state_n = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (baud_end) begin
          baud_n  = '0;
          state_n = S_DATA;
        end else baud_n = baud_cnt + 1'b1;
      end
      S_DATA: begin
        tx = shreg[0];
        if (baud_end) begin
          baud_n  = '0;
          shreg_n = shreg >> 1;
          par_n   = par ^ shreg[0];
          if (bit_cnt == BIT_LAST) begin
            bit_n = '0;
`ifdef OUT_UART_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else bit_n = bit_cnt + 1'b1;
        end else baud_n = baud_cnt + 1'b1;
      end
      S_PARITY: begin
        tx = par;
        if (baud_end) begin
          baud_n  = '0;
          state_n = S_STOP;
        end else baud_n = baud_cnt + 1'b1;
      end
      S_STOP: begin
        tx = 1'b1;
        if (baud_end) begin
          baud_n = '0;
          par_n  = 1'b0;
          // Next byte already sits in shreg[7:0] after the data shifts.
          if (byte_idx != BYTE_LAST) begin
            byte_n  = byte_idx + 1'b1;
            state_n = S_START;
          end else state_n = S_IDLE;
        end else baud_n = baud_cnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      last_q   <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      byte_idx <= byte_n;
      shreg    <= shreg_n;
      par      <= par_n;
      last_q   <= out_data;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_out_uart_tx.sv
// Randomised scoreboard bench for out_uart_tx: abstract word/timing model feeds an
// expected-frame queue; a line monitor decodes tx and compares frames and flags.
module tb_out_uart_tx;

  localparam int DW    = 16;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int NB    = DW / 8;
`ifdef OUT_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int L = NB * FB * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] out_data = '0;
  logic          tx, busy, fifo_full, overflow;

  out_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .out_data  (out_data),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: words waiting to be sent, and the cycle the line is free again.
  typedef struct { logic [DW-1:0] w; int start; } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] m_fifo[$];
  int            act_until = -1;
  bit            m_ovf = 1'b0;
  logic [DW-1:0] m_last = '0;
  bit            rst_edge = 1'b0;
  bit            started = 1'b0;

  always @(posedge clk) begin : model
    bit do_pop;
    int pre;
    exp_t e;
    cyc++;
    rst_edge = !rst_n;
    if (!rst_n) begin
      started = 1'b1;
      m_fifo.delete();
      exp_q.delete();
      act_until = -1;
      m_ovf = 1'b0;
      m_last = '0;
    end else begin
      pre = m_fifo.size();
      do_pop = (cyc > act_until) && (pre > 0);
      if (do_pop) begin
        e.w = m_fifo.pop_front();
        e.start = cyc;
        exp_q.push_back(e);
        act_until = cyc + L;
      end
      if (out_data != m_last) begin
        if (pre == DEPTH && !do_pop) m_ovf = 1'b1;
        else m_fifo.push_back(out_data);
      end
      m_last = out_data;
    end
  end

  // Ideal line level at a given cycle offset into a word's transmission.
  function automatic bit exp_bit(input logic [DW-1:0] w, input int off);
    int b, j;
    logic [7:0] by;
    b  = off / (FB * CPB);
    j  = (off % (FB * CPB)) / CPB;
    by = w[b*8 +: 8];
    if (j == 0) return 1'b0;
    if (j <= 8) return by[j-1];
    if (FB == 11 && j == 9) return ^by;
    return 1'b1;
  endfunction

  bit            in_frame = 1'b0;
  int            fidx = 0;
  int            bad_off = -1;
  exp_t          cur;
  logic [DW-1:0] dec;

  always @(negedge clk) begin : monitor
    int b, j, ph;
    if (started) begin
      chk("busy", busy, (cyc < act_until) || (m_fifo.size() > 0));
      chk("fifo_full", fifo_full, m_fifo.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
      if (rst_edge) begin
        in_frame = 1'b0;
        chk("tx_after_reset", tx, 1'b1);
      end else begin
        if (!in_frame) begin
          if (tx === 1'b0) begin
            if (exp_q.size() == 0) flag_fail("spurious_start");
            else begin
              cur = exp_q.pop_front();
              chk("start_cycle", cyc, cur.start);
              in_frame = 1'b1;
              fidx = 0;
              bad_off = -1;
              dec = '0;
            end
          end else if (exp_q.size() > 0 && exp_q[0].start < cyc) begin
            flag_fail("missing_start");
            void'(exp_q.pop_front());
          end
        end
        if (in_frame) begin
          if (tx !== exp_bit(cur.w, fidx) && bad_off < 0) bad_off = fidx;
          b  = fidx / (FB * CPB);
          j  = (fidx % (FB * CPB)) / CPB;
          ph = fidx % CPB;
          if (ph == CPB / 2 && j >= 1 && j <= 8) dec[b*8 + j - 1] = tx;
          fidx++;
          if (fidx == L) begin
            in_frame = 1'b0;
            chk("frame_wave_first_bad_offset", bad_off, -1);
            chk("decoded_word", dec, cur.w);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] v;
    int g;
    rst_n = 1'b0;
    out_data = '0;
    tick(3);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_full", fifo_full, 1'b0);
    chk("reset_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // 00A5: tx stays high one edge, falls on the second.
    out_data = 16'h00A5;
    tick(1);
    chk("t1_tx_hold", tx, 1'b1);
    tick(1);
    chk("t1_tx_start", tx, 1'b0);
    tick(L + 10);

    // Held value: one word only.
    out_data = 16'h1234;
    tick(200);

    // Six values on consecutive edges: w6 dropped on full FIFO.
    for (int i = 1; i <= 6; i++) begin
      out_data = DW'(i * 16'h1111);
      tick(1);
    end
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_full", fifo_full, 1'b1);
    tick(6 * (L + 1) + 20);

    // Reset in the middle of byte 0 data bits.
    out_data = 16'hBEEF;
    tick(8);
    rst_n = 1'b0;
    out_data = '0;
    tick(1);
    rst_n = 1'b1;
    chk("t5_tx", tx, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_ovf", overflow, 1'b0);
    tick(L + 20);

    // Change on the edge a full FIFO pops: accepted, no overflow.
    for (int i = 1; i <= 5; i++) begin
      out_data = DW'(16'hA000 + i);
      tick(1);
    end
    g = 0;
    while (cyc != act_until && g < 500) begin
      tick(1);
      g++;
    end
    if (g >= 500) flag_fail("t6_timeout");
    out_data = 16'hA006;
    tick(1);
    chk("t6_ovf", overflow, 1'b0);
    chk("t6_full", fifo_full, 1'b1);
    tick(6 * (L + 1) + 20);

    // Random values, holds and occasional resets.
    v = out_data;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) != 0) v = DW'($urandom);
      else if ($urandom_range(0, 3) == 0) v = '0;
      out_data = v;
      tick($urandom_range(0, 2) == 0 ? 1 : $urandom_range(1, 120));
    end

    g = 0;
    while ((m_fifo.size() > 0 || exp_q.size() > 0 || in_frame || cyc < act_until) && g < 3000) begin
      tick(1);
      g++;
    end
    if (g >= 3000) flag_fail("drain_timeout");
    tick(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
